// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the ID-stage hazard/stall controller.
package hazard_stall_unit_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_HOLD2 = 1'b1
    } state_t;

    // Control word loaded into ID/EX when a bubble is injected.
    localparam logic [7:0] IDEX_NOP_CTRL = 8'h00;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard detection: classifies the ID instruction as needing
// one or two stall cycles against the instructions in EX and MEM.
module hazard_detect #(
    parameter int NB_REG_ADDR = 5
) (
    input  logic [NB_REG_ADDR-1:0] i_rs_id,
    input  logic [NB_REG_ADDR-1:0] i_rt_id,
    input  logic                   i_use_rs,
    input  logic                   i_use_rt,
    input  logic                   i_branch_id,
    input  logic                   i_jump_rs_id,
    input  logic                   i_we_ex,
    input  logic                   i_memread_ex,
    input  logic [NB_REG_ADDR-1:0] i_rd_ex,
    input  logic                   i_memread_mem,
    input  logic [NB_REG_ADDR-1:0] i_rd_mem,
    output logic                   o_need1,
    output logic                   o_need2
);

    logic w_mrs_ex;
    logic w_mrt_ex;
    logic w_mrs_mem;
    logic w_mrt_mem;
    logic w_ctrl;
    logic w_hit_ex;
    logic w_hit_mem;

    // Register 0 is hardwired, so it never creates a dependency; jr/jalr only read rs.
    assign w_mrs_ex  = i_use_rs & (i_rs_id == i_rd_ex) & (i_rd_ex != {NB_REG_ADDR{1'b0}});
    assign w_mrt_ex  = i_use_rt & ~i_jump_rs_id & (i_rt_id == i_rd_ex) & (i_rd_ex != {NB_REG_ADDR{1'b0}});
    assign w_mrs_mem = i_use_rs & (i_rs_id == i_rd_mem) & (i_rd_mem != {NB_REG_ADDR{1'b0}});
    assign w_mrt_mem = i_use_rt & ~i_jump_rs_id & (i_rt_id == i_rd_mem) & (i_rd_mem != {NB_REG_ADDR{1'b0}});

    assign w_ctrl    = i_branch_id | i_jump_rs_id;
    assign w_hit_ex  = w_mrs_ex | w_mrt_ex;
    assign w_hit_mem = w_mrs_mem | w_mrt_mem;

    assign o_need2 = w_ctrl & i_memread_ex & w_hit_ex;
    assign o_need1 = ~o_need2 & (
                         (i_memread_ex & w_hit_ex)
                       | (w_ctrl & i_we_ex & ~i_memread_ex & w_hit_ex)
                       | (w_ctrl & i_memread_mem & w_hit_mem));

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard controller: stall/bubble/flush generation, two-cycle
// load-to-branch sequencing and a saturating stall-cycle counter.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int NB_REG_ADDR = 5,
    parameter int NB_CNT      = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic [NB_REG_ADDR-1:0] i_rs_id,
    input  logic [NB_REG_ADDR-1:0] i_rt_id,
    input  logic                   i_use_rs,
    input  logic                   i_use_rt,
    input  logic                   i_branch_id,
    input  logic                   i_jump_rs_id,
    input  logic                   i_we_ex,
    input  logic                   i_memread_ex,
    input  logic [NB_REG_ADDR-1:0] i_rd_ex,
    input  logic                   i_memread_mem,
    input  logic [NB_REG_ADDR-1:0] i_rd_mem,
    input  logic                   i_ctrl_taken,
    output logic                   o_stall_pc,
    output logic                   o_stall_ifid,
    output logic                   o_bubble_idex,
    output logic                   o_flush_ifid,
    output logic [NB_CNT-1:0]      o_stall_count
);

    state_t            r_state;
    state_t            w_state_next;
    logic [NB_CNT-1:0] r_stall_count;
    logic              w_need1;
    logic              w_need2;
    logic              w_stall;
    logic              w_flush;

    hazard_detect #(
        .NB_REG_ADDR (NB_REG_ADDR)
    ) u_hazard_detect (
        .i_rs_id       (i_rs_id),
        .i_rt_id       (i_rt_id),
        .i_use_rs      (i_use_rs),
        .i_use_rt      (i_use_rt),
        .i_branch_id   (i_branch_id),
        .i_jump_rs_id  (i_jump_rs_id),
        .i_we_ex       (i_we_ex),
        .i_memread_ex  (i_memread_ex),
        .i_rd_ex       (i_rd_ex),
        .i_memread_mem (i_memread_mem),
        .i_rd_mem      (i_rd_mem),
        .o_need1       (w_need1),
        .o_need2       (w_need2)
    );

    // State register for the two-cycle stall sequencer.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and stall decode; HOLD2 delivers the second stall on the next valid cycle.
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (i_valid) begin
                    w_stall      = w_need1 | w_need2;
                    w_state_next = w_need2 ? ST_HOLD2 : ST_RUN;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_HOLD2: begin
                if (i_valid) begin
                    w_stall      = 1'b1;
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_HOLD2;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
        if (i_reset) begin
            w_stall = 1'b0;
        end else begin
            w_stall = w_stall;
        end
    end

    // An unresolved (stalled) control instruction must not flush.
    assign w_flush = i_valid & i_ctrl_taken & ~w_stall & ~i_reset;

    // Saturating count of stall cycles for debug visibility.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_stall_count <= {NB_CNT{1'b0}};
        end else if (w_stall && (r_stall_count != {NB_CNT{1'b1}})) begin
            r_stall_count <= r_stall_count + {{(NB_CNT-1){1'b0}}, 1'b1};
        end else begin
            r_stall_count <= r_stall_count;
        end
    end

    assign o_stall_pc    = w_stall;
    assign o_stall_ifid  = w_stall;
    assign o_bubble_idex = w_stall;
    assign o_flush_ifid  = w_flush;
    assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed self-checking bench for hazard_stall_unit (16-bit and 4-bit counter instances).
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [4:0]  rs_id, rt_id, rd_ex, rd_mem;
    logic        use_rs, use_rt, br, jr, we_ex, mr_ex, mr_mem, taken;
    logic        stall_pc, stall_ifid, bubble, flush;
    logic [15:0] cnt;
    logic        stall_pc4, stall_ifid4, bubble4, flush4;
    logic [3:0]  cnt4;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    hazard_stall_unit u_dut (
        .i_clock(clk), .i_reset(rst), .i_valid(valid),
        .i_rs_id(rs_id), .i_rt_id(rt_id), .i_use_rs(use_rs), .i_use_rt(use_rt),
        .i_branch_id(br), .i_jump_rs_id(jr), .i_we_ex(we_ex), .i_memread_ex(mr_ex),
        .i_rd_ex(rd_ex), .i_memread_mem(mr_mem), .i_rd_mem(rd_mem), .i_ctrl_taken(taken),
        .o_stall_pc(stall_pc), .o_stall_ifid(stall_ifid), .o_bubble_idex(bubble),
        .o_flush_ifid(flush), .o_stall_count(cnt)
    );

    hazard_stall_unit #(.NB_REG_ADDR(5), .NB_CNT(4)) u_dut4 (
        .i_clock(clk), .i_reset(rst), .i_valid(valid),
        .i_rs_id(rs_id), .i_rt_id(rt_id), .i_use_rs(use_rs), .i_use_rt(use_rt),
        .i_branch_id(br), .i_jump_rs_id(jr), .i_we_ex(we_ex), .i_memread_ex(mr_ex),
        .i_rd_ex(rd_ex), .i_memread_mem(mr_mem), .i_rd_mem(rd_mem), .i_ctrl_taken(taken),
        .o_stall_pc(stall_pc4), .o_stall_ifid(stall_ifid4), .o_bubble_idex(bubble4),
        .o_flush_ifid(flush4), .o_stall_count(cnt4)
    );

    task automatic idle();
        valid = 1'b1; rs_id = 5'd0; rt_id = 5'd0; rd_ex = 5'd0; rd_mem = 5'd0;
        use_rs = 1'b0; use_rt = 1'b0; br = 1'b0; jr = 1'b0; we_ex = 1'b0;
        mr_ex = 1'b0; mr_mem = 1'b0; taken = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        taken = 1'b1;
        mr_ex = 1'b1; rd_ex = 5'd3; use_rs = 1'b1; rs_id = 5'd3;
        #1;
        n_tests++;
        if ({stall_pc, stall_ifid, bubble, flush} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_outputs got %b want 0000", {stall_pc, stall_ifid, bubble, flush});
        end
        n_tests++;
        if (cnt !== 16'd0 || cnt4 !== 4'd0) begin
            n_fail++; $display("FAIL reset_count got %0d/%0d want 0/0", cnt, cnt4);
        end
        @(negedge clk);
        rst = 1'b0;
        idle();
    endtask

    task automatic test_load_use();
        do_reset();
        mr_ex = 1'b1; rd_ex = 5'd3; use_rs = 1'b1; rs_id = 5'd3;
        #1;
        n_tests++;
        if ({stall_pc, stall_ifid, bubble, flush} !== 4'b1110) begin
            n_fail++; $display("FAIL load_use_stall got %b want 1110", {stall_pc, stall_ifid, bubble, flush});
        end
        @(negedge clk);
        idle();
        #1;
        n_tests++;
        if ({stall_pc, stall_ifid, bubble, flush} !== 4'b0000) begin
            n_fail++; $display("FAIL load_use_release got %b want 0000", {stall_pc, stall_ifid, bubble, flush});
        end
        @(negedge clk);
        n_tests++;
        if (cnt !== 16'd1) begin
            n_fail++; $display("FAIL load_use_count got %0d want 1", cnt);
        end
    endtask

    task automatic test_branch_load();
        do_reset();
        mr_ex = 1'b1; rd_ex = 5'd5; br = 1'b1; use_rs = 1'b1; rs_id = 5'd1; use_rt = 1'b1; rt_id = 5'd5;
        #1;
        n_tests++;
        if (stall_pc !== 1'b1) begin
            n_fail++; $display("FAIL br_load_stall1 got %b want 1", stall_pc);
        end
        @(negedge clk);
        idle();
        #1;
        n_tests++;
        if ({stall_pc, bubble, flush} !== 3'b110) begin
            n_fail++; $display("FAIL br_load_stall2 got %b want 110", {stall_pc, bubble, flush});
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (stall_pc !== 1'b0 || cnt !== 16'd2) begin
            n_fail++; $display("FAIL br_load_done stall=%b cnt=%0d want 0/2", stall_pc, cnt);
        end
        // Same hazard with an invalid cycle between the two stalls.
        do_reset();
        mr_ex = 1'b1; rd_ex = 5'd5; br = 1'b1; use_rt = 1'b1; rt_id = 5'd5;
        @(negedge clk);
        idle();
        valid = 1'b0;
        taken = 1'b1;
        #1;
        n_tests++;
        if ({stall_pc, stall_ifid, bubble, flush} !== 4'b0000) begin
            n_fail++; $display("FAIL br_load_invalid got %b want 0000", {stall_pc, stall_ifid, bubble, flush});
        end
        @(negedge clk);
        n_tests++;
        if (cnt !== 16'd1) begin
            n_fail++; $display("FAIL br_load_frozen_count got %0d want 1", cnt);
        end
        idle();
        #1;
        n_tests++;
        if (stall_pc !== 1'b1) begin
            n_fail++; $display("FAIL br_load_deferred_stall got %b want 1", stall_pc);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (stall_pc !== 1'b0 || cnt !== 16'd2) begin
            n_fail++; $display("FAIL br_load_deferred_done stall=%b cnt=%0d want 0/2", stall_pc, cnt);
        end
    endtask

    task automatic test_alu_ctrl();
        do_reset();
        we_ex = 1'b1; rd_ex = 5'd7; jr = 1'b1; use_rs = 1'b1; rs_id = 5'd7;
        #1;
        n_tests++;
        if (stall_pc !== 1'b1) begin
            n_fail++; $display("FAIL alu_jr_stall got %b want 1", stall_pc);
        end
        @(negedge clk);
        jr = 1'b0;
        #1;
        n_tests++;
        if (stall_pc !== 1'b0 || cnt !== 16'd1) begin
            n_fail++; $display("FAIL alu_add_forward stall=%b cnt=%0d want 0/1", stall_pc, cnt);
        end
        // jr ignores rt even if the decoder flags it.
        jr = 1'b1; rs_id = 5'd2; use_rt = 1'b1; rt_id = 5'd7;
        #1;
        n_tests++;
        if (stall_pc !== 1'b0) begin
            n_fail++; $display("FAIL jr_ignores_rt got %b want 0", stall_pc);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_zero_and_mem();
        do_reset();
        mr_ex = 1'b1; rd_ex = 5'd0; use_rs = 1'b1; rs_id = 5'd0; br = 1'b1;
        #1;
        n_tests++;
        if (stall_pc !== 1'b0) begin
            n_fail++; $display("FAIL reg0_no_stall got %b want 0", stall_pc);
        end
        @(negedge clk);
        idle();
        mr_mem = 1'b1; rd_mem = 5'd4; br = 1'b1; use_rs = 1'b1; rs_id = 5'd4;
        #1;
        n_tests++;
        if (stall_pc !== 1'b1) begin
            n_fail++; $display("FAIL mem_load_branch got %b want 1", stall_pc);
        end
        @(negedge clk);
        br = 1'b0;
        #1;
        n_tests++;
        if (stall_pc !== 1'b0 || cnt !== 16'd1) begin
            n_fail++; $display("FAIL mem_load_add stall=%b cnt=%0d want 0/1", stall_pc, cnt);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        taken = 1'b1; br = 1'b1; use_rs = 1'b1; rs_id = 5'd1;
        #1;
        n_tests++;
        if ({stall_pc, flush} !== 2'b01) begin
            n_fail++; $display("FAIL flush_taken got %b want 01", {stall_pc, flush});
        end
        @(negedge clk);
        we_ex = 1'b1; rd_ex = 5'd1;
        #1;
        n_tests++;
        if ({stall_pc, flush} !== 2'b10) begin
            n_fail++; $display("FAIL flush_vs_stall got %b want 10", {stall_pc, flush});
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset_hold2();
        do_reset();
        mr_ex = 1'b1; rd_ex = 5'd3; use_rs = 1'b1; rs_id = 5'd3;
        repeat (4) @(negedge clk);
        br = 1'b1;
        @(negedge clk);
        n_tests++;
        if (cnt !== 16'd5) begin
            n_fail++; $display("FAIL hold2_precount got %0d want 5", cnt);
        end
        idle();
        taken = 1'b1;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({stall_pc, stall_ifid, bubble, flush} !== 4'b0000 || cnt !== 16'd0) begin
            n_fail++; $display("FAIL hold2_async_reset out=%b cnt=%0d want 0000/0",
                               {stall_pc, stall_ifid, bubble, flush}, cnt);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if ({stall_pc, flush} !== 2'b01) begin
            n_fail++; $display("FAIL hold2_back_to_run got %b want 01", {stall_pc, flush});
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        mr_ex = 1'b1; rd_ex = 5'd9; use_rt = 1'b1; rt_id = 5'd9;
        repeat (20) @(negedge clk);
        n_tests++;
        if (cnt4 !== 4'hF || stall_pc4 !== 1'b1) begin
            n_fail++; $display("FAIL saturate_4bit cnt=%0h stall=%b want f/1", cnt4, stall_pc4);
        end
        n_tests++;
        if (cnt !== 16'd20) begin
            n_fail++; $display("FAIL count_16bit got %0d want 20", cnt);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_load();
        test_alu_ctrl();
        test_zero_and_mem();
        test_flush();
        test_reset_hold2();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline hazard controller in the ID stage; sits directly upstream of the forwarding unit and the ID/EX register.
- Detects hazards that forwarding cannot cover: load-use, and ID-resolved branch/jump-rs operands not yet available.
- Freezes PC and IF/ID, injects a bubble into ID/EX, and flushes IF/ID on taken control transfers.
- A small FSM sequences the two-cycle stall for a branch that depends on a load; a saturating counter records stall cycles for debug.

Parameters:
- NB_REG_ADDR, 5, register address width
- NB_CNT, 16, stall counter width

Ports:
- i_clock  in  1  single clock; all state on the rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_valid  in  1  pipeline advance enable; when 0, FSM and counter frozen and all control outputs 0
- i_rs_id  in  NB_REG_ADDR  rs of the instruction in ID
- i_rt_id  in  NB_REG_ADDR  rt of the instruction in ID
- i_use_rs  in  1  ID instruction reads rs
- i_use_rt  in  1  ID instruction reads rt
- i_branch_id  in  1  ID instruction is beq/bne, compared in ID
- i_jump_rs_id  in  1  ID instruction is jr/jalr
- i_we_ex  in  1  EX instruction writes the register file
- i_memread_ex  in  1  EX instruction is a load
- i_rd_ex  in  NB_REG_ADDR  destination of the EX instruction
- i_memread_mem  in  1  MEM instruction is a load
- i_rd_mem  in  NB_REG_ADDR  destination of the MEM instruction
- i_ctrl_taken  in  1  taken branch or jump resolved in ID this cycle
- o_stall_pc  out  1  hold PC
- o_stall_ifid  out  1  hold IF/ID
- o_bubble_idex  out  1  load NOP controls into ID/EX
- o_flush_ifid  out  1  replace IF/ID with NOP
- o_stall_count  out  NB_CNT  saturating count of stall cycles

Behaviour:
- Register matches: mrs_x = i_use_rs & (i_rs_id == i_rd_x) & (i_rd_x != 0); mrt_x is the same for rt. x is EX or MEM. Register 0 never matches.
- ctrl = i_branch_id | i_jump_rs_id. For a jump-rs instruction, only rs counts.
- need2 = ctrl & i_memread_ex & (mrs_ex | mrt_ex)
- need1 (when not need2) is true for any of:
  - load-use: i_memread_ex & (mrs_ex | mrt_ex)
  - ALU result in EX feeding an ID compare: ctrl & i_we_ex & ~i_memread_ex & (mrs_ex | mrt_ex)
  - load in MEM feeding an ID compare: ctrl & i_memread_mem & (mrs_mem | mrt_mem)
- FSM states: RUN and HOLD2.
  - RUN: stall = i_valid & (need1 | need2). On need2, go to HOLD2; otherwise stay in RUN.
  - HOLD2: stall = i_valid, regardless of detection. On i_valid, return to RUN; otherwise stay in HOLD2.
- o_stall_pc = o_stall_ifid = o_bubble_idex = stall. These are combinational, so the stall takes effect in the detecting cycle with zero latency.
- o_flush_ifid = i_valid & i_ctrl_taken & ~stall. A stalled control instruction has not resolved, so stall takes priority over flush when both would apply.
- o_stall_count increments by 1 in each cycle where stall = 1. It saturates at all-ones and never wraps.
- Reset (asynchronous, any time, including mid-HOLD2):
  - state goes to RUN and o_stall_count goes to 0.
  - All combinational outputs evaluate with state = RUN; while i_reset is high they are additionally forced to 0.
- i_valid = 0 in HOLD2: remain in HOLD2, no count, outputs 0. The second stall cycle is still delivered on the next valid cycle.
- In HOLD2 the hazard has moved to MEM, so need1 recomputed in RUN would also cover it. HOLD2 makes the 2-cycle stall deterministic, independent of EX/MEM decode timing.

Decomposition:
- Shared package: FSM state encoding (ST_RUN = 1'b0, ST_HOLD2 = 1'b1) and the NOP control constant used by ID/EX.
- One sub-module: hazard_detect. It is purely combinational and produces need1/need2. The FSM, counter and output logic stay in the top module.

Test Plan:
1. lw $3 in EX (i_memread_ex = 1, i_rd_ex = 3), ID add using rs = 3 → stall for exactly 1 cycle, no flush, count = 1; next cycle (no match) stall = 0.
2. lw $5 in EX, ID beq with rt = 5 → 2 consecutive stall cycles (RUN→HOLD2→RUN), count = 2. Repeat with i_valid = 0 inserted between them → still exactly 2 stalls, no stall while invalid.
3. ALU op writing $7 in EX (i_we_ex = 1, i_memread_ex = 0), ID jr $7 → 1 stall. Same with ID add using $7 → 0 stalls, since forwarding covers it.
4. i_rd_ex = 0 with a load and ID using rs = 0 → no stall. Load in MEM to $4 with ID beq on $4 → 1 stall. ID add on $4 with the load in MEM → 0 stalls.
5. i_ctrl_taken = 1, no hazard → o_flush_ifid = 1 for that cycle. i_ctrl_taken = 1 together with need1 → flush = 0, stall = 1.
6. Assert i_reset while in HOLD2 with count = 0x0005 → state RUN and count 0 immediately, before the next clock edge, all outputs 0. Preload near saturation (NB_CNT = 4, run 20 stalls) → count holds at 0xF.
